// File: rtl/fir_out_pkg.sv
// fir_out_pkg: shared widths, saturation limits and sample types for the FIR output scaler.
package fir_out_pkg;
  localparam int IN_W  = 48;
  localparam int OUT_W = 24;
  typedef logic signed [IN_W-1:0]  in_sample_t;
  typedef logic signed [OUT_W-1:0] out_sample_t;
  localparam out_sample_t OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam out_sample_t OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: synchronous FIFO with occupancy count; reads show the head word, zero when empty.
module fir_out_fifo
  import fir_out_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  out_sample_t   wr_data,
  input  logic          rd_en,
  output out_sample_t   rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  out_sample_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push, pop;
  always_comb begin
    empty    = level_q == '0;
    full     = level_q == (AW+1)'(DEPTH);
    pop      = rd_en & ~empty;
    // a full FIFO still accepts a write when the head leaves on the same edge
    push     = wr_en & (~full | pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    level    = level_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wr_data;
endmodule

// File: rtl/fir_output_scaler.sv
// fir_output_scaler: round-half-up, shift and saturate 48-bit FIR results to 24 bits,
// then buffer them for an AXI-Stream consumer with sticky saturation/drop flags.
module fir_output_scaler
  import fir_out_pkg::*;
#(
  parameter int SHIFT = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     s_axis_data_tvalid,
  input  logic [IN_W-1:0]          s_axis_data_tdata,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready,
  output logic [OUT_W-1:0]         m_axis_data_tdata,
  input  logic                     clear_flags,
  output logic                     sat_flag,
  output logic                     drop_flag,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam logic signed [IN_W:0] RND    = (IN_W+1)'(1) << (SHIFT-1);
  localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'(OUT_MAX);
  localparam logic signed [IN_W:0] SAT_LO = ~SAT_HI;
  logic signed [IN_W:0] rounded, shifted;
  logic                 clamp;
  logic                 s1_valid_q, s1_valid_d;
  out_sample_t          s1_data_q, s1_data_d, head;
  logic                 sat_q, sat_d, drop_q, drop_d;
  logic                 fifo_full, fifo_empty, drop;
  always_comb begin
    rounded    = $signed({s_axis_data_tdata[IN_W-1], s_axis_data_tdata}) + RND;
    shifted    = rounded >>> SHIFT;
    clamp      = (shifted > SAT_HI) | (shifted < SAT_LO);
    s1_valid_d = s_axis_data_tvalid;
    s1_data_d  = !s_axis_data_tvalid ? s1_data_q :
                 shifted > SAT_HI    ? OUT_MAX :
                 shifted < SAT_LO    ? OUT_MIN : shifted[OUT_W-1:0];
    drop       = s1_valid_q & fifo_full & ~(m_axis_data_tready & ~fifo_empty);
    // a set event outranks a clear in the same cycle
    sat_d      = (s_axis_data_tvalid & clamp) | (sat_q & ~clear_flags);
    drop_d     = drop | (drop_q & ~clear_flags);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      sat_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      sat_q      <= sat_d;
      drop_q     <= drop_d;
    end
  fir_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (s1_valid_q),
    .wr_data (s1_data_q),
    .rd_en   (m_axis_data_tready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );
  assign m_axis_data_tvalid = ~fifo_empty;
  assign m_axis_data_tdata  = head;
  assign sat_flag           = sat_q;
  assign drop_flag          = drop_q;
endmodule

// File: tb/tb_fir_output_scaler.sv
// tb_fir_output_scaler: directed and randomized checks of scaling, FIFO behaviour, flags and reset.
module tb_fir_output_scaler;
  logic        clk = 0, resetn = 0, in_valid = 0, ready = 0, clear = 0;
  logic [47:0] in_data = '0;
  logic        out_valid, sat, drop;
  logic [23:0] out_data;
  logic [4:0]  level;
  int checks = 0, errors = 0;

  fir_output_scaler #(.SHIFT(16), .DEPTH(16)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .s_axis_data_tvalid (in_valid),
    .s_axis_data_tdata  (in_data),
    .m_axis_data_tvalid (out_valid),
    .m_axis_data_tready (ready),
    .m_axis_data_tdata  (out_data),
    .clear_flags        (clear),
    .sat_flag           (sat),
    .drop_flag          (drop),
    .fifo_level         (level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // returns {saturated, scaled value}
  function automatic logic [24:0] ref_scale(input logic [47:0] d);
    longint v;
    v = longint'($signed(d));
    v = (v + 64'sd32768) >>> 16;
    if (v > 64'sd8388607) return {1'b1, 24'h7FFFFF};
    if (v < -64'sd8388608) return {1'b1, 24'h800000};
    return {1'b0, v[23:0]};
  endfunction

  task automatic clear_all_flags();
    @(negedge clk) clear = 1;
    @(negedge clk) clear = 0;
  endtask

  task automatic test_reset();
    resetn = 0; in_valid = 1; in_data = {$urandom(), $urandom()};
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL reset_tdata got %h want 000000", out_data); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop); end
    in_valid = 0; resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_rounding();
    logic [47:0] ins [4] = '{48'h000000018000, 48'hFFFFFFFE8000, 48'h7FFFFFFFFFFF, 48'h800000000000};
    logic [23:0] exps [4] = '{24'h000002, 24'hFFFFFF, 24'h7FFFFF, 24'h800000};
    logic        esat [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = ins[i];
      @(negedge clk) in_valid = 0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early[%0d] tvalid got %b want 0", i, out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency2[%0d] tvalid got %b want 1", i, out_valid); end
      checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL scale[%0d] got %h want %h", i, out_data, exps[i]); end
      checks++; if (sat !== esat[i]) begin errors++; $display("FAIL sat[%0d] got %b want %b", i, sat, esat[i]); end
      @(negedge clk);
    end
    clear_all_flags();
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_clear got %b want 0", sat); end
    clear = 1; in_valid = 1; in_data = 48'h7FFFFFFFFFFF;
    @(negedge clk) clear = 0; in_valid = 0;
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_set_beats_clear got %b want 1", sat); end
    repeat (3) @(negedge clk);
    clear_all_flags();
  endtask

  task automatic test_fill_drop();
    ready = 0;
    for (int i = 1; i <= 18; i++) begin
      in_valid = 1; in_data = 48'(i) << 16;
      @(negedge clk);
    end
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d want 16", level); end
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL fill_drop got %b want 1", drop); end
    ready = 1;
    for (int k = 1; k <= 16; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 24'(k)) begin errors++; $display("FAIL drain[%0d] got v=%b %h want v=1 %h", k, out_valid, out_data, 24'(k)); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL drain_empty got v=%b lvl=%0d want v=0 lvl=0", out_valid, level); end
    ready = 0;
    clear_all_flags();
  endtask

  task automatic test_full_push_pop();
    ready = 0;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1; in_data = 48'(i) << 16;
      @(negedge clk);
    end
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (level !== 5'd16 || drop !== 1'b0) begin errors++; $display("FAIL full_setup got lvl=%0d drop=%b want lvl=16 drop=0", level, drop); end
    in_valid = 1; in_data = 48'd100 << 16;
    @(negedge clk) in_valid = 0; ready = 1;
    @(negedge clk) ready = 0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_pushpop_level got %0d want 16", level); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL full_pushpop_drop got %b want 0", drop); end
    ready = 1;
    for (int k = 0; k < 16; k++) begin
      logic [23:0] e;
      e = (k == 15) ? 24'd100 : 24'(k + 2);
      checks++; if (out_valid !== 1'b1 || out_data !== e) begin errors++; $display("FAIL full_drain[%0d] got v=%b %h want v=1 %h", k, out_valid, out_data, e); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain_empty got %b want 0", out_valid); end
    ready = 0;
  endtask

  task automatic test_random();
    logic [23:0] q[$];
    logic        pipe_v = 0, exp_sat = 0, exp_drop = 0, pop;
    logic [24:0] pipe_r = '0;
    logic [63:0] r;
    int          bad = 0;
    clear_all_flags();
    for (int cyc = 0; cyc < 420; cyc++) begin
      checks++;
      if (out_valid !== (q.size() != 0) || level !== 5'(q.size()) || sat !== exp_sat || drop !== exp_drop ||
          (q.size() != 0 && out_data !== q[0])) begin
        errors++;
        if (bad++ < 10) $display("FAIL random[%0d] got v=%b d=%h lvl=%0d sat=%b drop=%b want v=%b d=%h lvl=%0d sat=%b drop=%b",
                                 cyc, out_valid, out_data, level, sat, drop, q.size() != 0,
                                 q.size() != 0 ? q[0] : 24'h0, q.size(), exp_sat, exp_drop);
      end
      ready = $urandom_range(0, 99) < 60;
      in_valid = cyc < 360;
      r = {$urandom(), $urandom()};
      in_data = ($urandom_range(0, 3) == 0) ? r[47:0] : {{8{r[39]}}, r[39:0]};
      pop = q.size() != 0 && ready;
      if (pop) void'(q.pop_front());
      if (pipe_v) begin
        if (q.size() < 16) q.push_back(pipe_r[23:0]);
        else exp_drop = 1;
      end
      pipe_v = in_valid;
      pipe_r = ref_scale(in_data);
      if (in_valid && pipe_r[24]) exp_sat = 1;
      @(negedge clk);
    end
    in_valid = 0; ready = 0;
    checks++; if (q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL random_drain got v=%b model=%0d want both empty", out_valid, q.size()); end
    clear_all_flags();
  endtask

  task automatic test_reset_mid();
    ready = 0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; in_data = 48'(i) << 16;
      @(negedge clk);
    end
    in_valid = 0;
    @(negedge clk);
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL mid_level got %0d want 5", level); end
    in_valid = 1; in_data = 48'd9 << 16;
    @(negedge clk) in_valid = 0; resetn = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0 || out_data !== 24'h0) begin errors++; $display("FAIL mid_reset got v=%b lvl=%0d d=%h want v=0 lvl=0 d=000000", out_valid, level, out_data); end
    @(negedge clk);
    @(negedge clk) resetn = 1; in_valid = 1; in_data = 48'd7 << 16;
    @(negedge clk) in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_release_early got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'd7 || level !== 5'd1) begin errors++; $display("FAIL mid_release got v=%b d=%h lvl=%0d want v=1 d=000007 lvl=1", out_valid, out_data, level); end
    ready = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got v=%b d=%h want v=0", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_fill_drop();
    test_full_push_pop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
